// File: rtl/conv_mac_engine_if.sv
// Bundles the three buses of the conv MAC engine: tap index stream in,
// SRAM read port out, and the output-neuron valid/ready port.
interface conv_mac_engine_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24,
   parameter int ADDR_W = 16
);
   // tap index stream
   logic                idx_valid;
   logic                idx_ready;
   logic [7:0]          m, r, c, n;
   logic [3:0]          i, j;
   logic                idx_first;
   logic                idx_last;
   // activation / weight SRAM read port
   logic                rd_en;
   logic [ADDR_W-1:0]   act_addr;
   logic [ADDR_W-1:0]   w_addr;
   logic [4*DATA_W-1:0] act_data;
   logic [4*DATA_W-1:0] w_data;
   // output neuron port
   logic                out_valid;
   logic                out_ready;
   logic [ACC_W-1:0]    out_data;
   logic [7:0]          out_m, out_r, out_c;

   // engine side
   modport slave (
      input  idx_valid, m, r, c, n, i, j, idx_first, idx_last,
      output idx_ready,
      output rd_en, act_addr, w_addr,
      input  act_data, w_data,
      output out_valid, out_data, out_m, out_r, out_c,
      input  out_ready
   );

   // environment side: index source, SRAMs, output-buffer writer
   modport master (
      output idx_valid, m, r, c, n, i, j, idx_first, idx_last,
      input  idx_ready,
      input  rd_en, act_addr, w_addr,
      output act_data, w_data,
      input  out_valid, out_data, out_m, out_r, out_c,
      output out_ready
   );
endinterface

// File: rtl/conv_mac_engine.sv
// Conv MAC engine: one tap per cycle -> SRAM reads -> 4-lane MAC into a
// per-neuron accumulator -> ReLU'd neuron on a valid/ready port.

// One signed multiplier lane.
module conv_mac_lane #(
   parameter int DATA_W = 8
) (
   input  logic signed [DATA_W-1:0]   act,
   input  logic signed [DATA_W-1:0]   wt,
   output logic signed [2*DATA_W-1:0] prod
);
   assign prod = act * wt;
endmodule

module conv_mac_engine #(
   parameter int K       = 5,
   parameter int IN_SIZE = 32,
   parameter int NGRP    = 1,
   parameter int DATA_W  = 8,
   parameter int ACC_W   = 24,
   parameter int ADDR_W  = 16,
   parameter int MEM_LAT = 1,
   parameter int RELU    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   conv_mac_engine_if.slave  bus
);
   localparam int NUM_LANES = 4;
   localparam int PROD_W    = 2 * DATA_W;
   localparam int EXT_W     = ACC_W - PROD_W;
   // stage 0 = rd_en cycle, stage STAGES-1 = data/accumulate cycle
   localparam int STAGES    = MEM_LAT + 1;

   localparam logic [ADDR_W-1:0] IN_SZ_A = ADDR_W'(IN_SIZE);
   localparam logic [ADDR_W-1:0] K_A     = ADDR_W'(K);
   localparam logic [ADDR_W-1:0] NGRP_A  = ADDR_W'(NGRP);

   typedef enum logic [1:0] {
      S_ACCUM = 2'd0,
      S_FLUSH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [STAGES-1:0]   vld_pipe_q, vld_pipe_d;
   logic [STAGES-1:0]   first_pipe_q, first_pipe_d;
   logic [STAGES-1:0]   last_pipe_q, last_pipe_d;
   logic [ADDR_W-1:0]   act_addr_q, act_addr_d;
   logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [7:0]          out_m_q, out_m_d;
   logic [7:0]          out_r_q, out_r_d;
   logic [7:0]          out_c_q, out_c_d;

   logic                accept;
   logic                last_done;
   logic [ADDR_W-1:0]   act_addr_calc;
   logic [ADDR_W-1:0]   w_addr_calc;
   logic signed [PROD_W-1:0] prod [NUM_LANES];
   logic [ACC_W-1:0]    lane_sum;

   assign accept    = bus.idx_valid && (state_q == S_ACCUM);
   // last tap's product lands in the accumulator at the end of this cycle
   assign last_done = vld_pipe_q[STAGES-1] && last_pipe_q[STAGES-1];

   // per-lane multipliers on the SRAM read data
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      conv_mac_lane #(.DATA_W(DATA_W)) u_lane (
         .act  (bus.act_data[l*DATA_W +: DATA_W]),
         .wt   (bus.w_data[l*DATA_W +: DATA_W]),
         .prod (prod[l])
      );
   end

   // sign-extend and sum the lane products to accumulator width
   always_comb begin
      lane_sum = '0;
      for (int l = 0; l < NUM_LANES; l++)
         lane_sum = lane_sum + {{EXT_W{prod[l][PROD_W-1]}}, prod[l]};
   end

   // tap addresses, wrapping modulo 2^ADDR_W
   always_comb begin
      act_addr_calc = ((ADDR_W'(bus.n) * IN_SZ_A + ADDR_W'(bus.r) + ADDR_W'(bus.i)) * IN_SZ_A)
                      + ADDR_W'(bus.c) + ADDR_W'(bus.j);
      w_addr_calc   = (((ADDR_W'(bus.m) * NGRP_A + ADDR_W'(bus.n)) * K_A + ADDR_W'(bus.i)) * K_A)
                      + ADDR_W'(bus.j);
   end

   // FSM next state: accept taps, drain the MAC pipe, hold the result
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ACCUM: if (accept && bus.idx_last) state_d = S_FLUSH;
         S_FLUSH: if (last_done)              state_d = S_HOLD;
         S_HOLD:  if (bus.out_ready)          state_d = S_ACCUM;
         default:                             state_d = S_ACCUM;
      endcase
   end

   // datapath next state: tag pipe, address regs, accumulator, coordinates
   always_comb begin
      vld_pipe_d   = {vld_pipe_q[STAGES-2:0], accept};
      first_pipe_d = {first_pipe_q[STAGES-2:0], bus.idx_first};
      last_pipe_d  = {last_pipe_q[STAGES-2:0], bus.idx_last};
      act_addr_d   = act_addr_q;
      w_addr_d     = w_addr_q;
      acc_d        = acc_q;
      out_m_d      = out_m_q;
      out_r_d      = out_r_q;
      out_c_d      = out_c_q;
      if (accept) begin
         act_addr_d = act_addr_calc;
         w_addr_d   = w_addr_calc;
      end
      if (accept && bus.idx_last) begin
         out_m_d = bus.m;
         out_r_d = bus.r;
         out_c_d = bus.c;
      end
      // first tap of a neuron loads, so nothing from the previous neuron leaks in
      if (vld_pipe_q[STAGES-1])
         acc_d = first_pipe_q[STAGES-1] ? lane_sum : acc_q + lane_sum;
   end

   // state registers; reset drops any partial neuron
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_ACCUM;
         vld_pipe_q   <= '0;
         first_pipe_q <= '0;
         last_pipe_q  <= '0;
         act_addr_q   <= '0;
         w_addr_q     <= '0;
         acc_q        <= '0;
         out_m_q      <= '0;
         out_r_q      <= '0;
         out_c_q      <= '0;
      end else begin
         state_q      <= state_d;
         vld_pipe_q   <= vld_pipe_d;
         first_pipe_q <= first_pipe_d;
         last_pipe_q  <= last_pipe_d;
         act_addr_q   <= act_addr_d;
         w_addr_q     <= w_addr_d;
         acc_q        <= acc_d;
         out_m_q      <= out_m_d;
         out_r_q      <= out_r_d;
         out_c_q      <= out_c_d;
      end
   end

   assign bus.idx_ready = (state_q == S_ACCUM);
   assign bus.rd_en     = vld_pipe_q[0];
   assign bus.act_addr  = act_addr_q;
   assign bus.w_addr    = w_addr_q;
   assign bus.out_valid = (state_q == S_HOLD);
   assign bus.out_data  = ((RELU != 0) && acc_q[ACC_W-1]) ? '0 : acc_q;
   assign bus.out_m     = out_m_q;
   assign bus.out_r     = out_r_q;
   assign bus.out_c     = out_c_q;
endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine: three instances (default, RELU=0,
// MEM_LAT=3) share one stimulus source; sel picks which one is active.
module tb_conv_mac_engine;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_run  = 0;
   int n_fail = 0;

   logic [1:0]  sel;
   logic        t_valid, t_first, t_last, t_out_ready;
   logic [7:0]  t_m, t_r, t_c, t_n;
   logic [3:0]  t_i, t_j;
   logic [31:0] act_word, w_word;
   logic [31:0] mem_act, mem_w;

   logic [2:0]  rdy_v, rd_v, ov_v;
   logic [15:0] aa_v [3];
   logic [15:0] wa_v [3];
   logic [23:0] od_v [3];
   logic [7:0]  om_v [3];
   logic [7:0]  or_v [3];
   logic [7:0]  oc_v [3];

   logic        rdy, rd_en_s, ov;
   logic [15:0] aa, wa;
   logic [23:0] od;
   logic [7:0]  om, orr, oc;

   conv_mac_engine_if ifs [3] ();

   conv_mac_engine u_dut0 (.clk(clk), .rst_n(rst_n), .bus(ifs[0]));
   conv_mac_engine #(.RELU(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(ifs[1]));
   conv_mac_engine #(.MEM_LAT(3)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(ifs[2]));

   for (genvar k = 0; k < 3; k++) begin : g_drv
      assign ifs[k].idx_valid = t_valid && (sel == 2'(k));
      assign ifs[k].m         = t_m;
      assign ifs[k].r         = t_r;
      assign ifs[k].c         = t_c;
      assign ifs[k].n         = t_n;
      assign ifs[k].i         = t_i;
      assign ifs[k].j         = t_j;
      assign ifs[k].idx_first = t_first;
      assign ifs[k].idx_last  = t_last;
      assign ifs[k].act_data  = mem_act;
      assign ifs[k].w_data    = mem_w;
      assign ifs[k].out_ready = t_out_ready;
      assign rdy_v[k] = ifs[k].idx_ready;
      assign rd_v[k]  = ifs[k].rd_en;
      assign ov_v[k]  = ifs[k].out_valid;
      assign aa_v[k]  = ifs[k].act_addr;
      assign wa_v[k]  = ifs[k].w_addr;
      assign od_v[k]  = ifs[k].out_data;
      assign om_v[k]  = ifs[k].out_m;
      assign or_v[k]  = ifs[k].out_r;
      assign oc_v[k]  = ifs[k].out_c;
   end

   always_comb begin
      rdy     = rdy_v[sel];
      rd_en_s = rd_v[sel];
      ov      = ov_v[sel];
      aa      = aa_v[sel];
      wa      = wa_v[sel];
      od      = od_v[sel];
      om      = om_v[sel];
      orr     = or_v[sel];
      oc      = oc_v[sel];
   end

   // SRAM model: data captured at the read, returned MEM_LAT cycles later;
   // a slot with no read returns large junk so mistimed sampling shows up
   logic [64:0] mp0, mp1, mp2, ent;
   always_ff @(posedge clk) begin
      mp0 <= {rd_en_s, act_word, w_word};
      mp1 <= mp0;
      mp2 <= mp1;
   end
   always_comb begin
      ent     = (sel == 2'd2) ? mp2 : mp0;
      mem_act = ent[64] ? ent[63:32] : 32'h7f7f7f7f;
      mem_w   = ent[64] ? ent[31:0]  : 32'h7f7f7f7f;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one tap and wait (bounded) until it is taken
   task automatic send_tap(input logic [3:0] i, input logic [3:0] j, input logic first, input logic last);
      int w;
      t_i = i; t_j = j; t_first = first; t_last = last; t_valid = 1'b1;
      w = 0;
      while (!rdy && w < 50) begin
         tick();
         w++;
      end
      if (!rdy) check("tap_ready_timeout", 32'(rdy), 32'd1);
      tick();
   endtask

   // taps start..24 of a K=5, NGRP=1 neuron, back to back
   task automatic run_taps(input logic [7:0] m, input logic [7:0] r, input logic [7:0] c,
                           input int start, input bit chk_addr);
      t_m = m; t_r = r; t_c = c; t_n = 8'd0;
      for (int t = start; t < 25; t++) begin
         send_tap(4'(t / 5), 4'(t % 5), t == 0, t == 24);
         if (chk_addr) begin
            if (t == 0) begin
               check("rd_en_tap0", 32'(rd_en_s), 32'd1);
               check("act_addr_tap0", 32'(aa), 32'd100);
               check("w_addr_tap0", 32'(wa), 32'd50);
            end
            if (t == 7) begin
               check("rd_en_tap7", 32'(rd_en_s), 32'd1);
               check("act_addr_tap7", 32'(aa), 32'd134);
               check("w_addr_tap7", 32'(wa), 32'd57);
            end
            if (t == 24) begin
               check("act_addr_tap24", 32'(aa), 32'd232);
               check("w_addr_tap24", 32'(wa), 32'd74);
            end
         end
      end
      t_valid = 1'b0;
   endtask

   // called one cycle after the last tap's accept; lat counts from the accept cycle
   task automatic wait_out(output int lat, output int low);
      lat = 1;
      low = 0;
      while (!ov && lat < 20) begin
         if (!rdy) low++;
         tick();
         lat++;
      end
      if (!ov) check("out_valid_timeout", 32'(ov), 32'd1);
   endtask

   int lat, low;

   initial begin
      rst_n = 1'b0; sel = 2'd0;
      t_valid = 1'b0; t_first = 1'b0; t_last = 1'b0; t_out_ready = 1'b0;
      t_m = '0; t_r = '0; t_c = '0; t_n = '0; t_i = '0; t_j = '0;
      act_word = '0; w_word = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset state
      for (int k = 0; k < 3; k++) begin
         sel = 2'(k);
         #1;
         check("rst_idx_ready", 32'(rdy), 32'd1);
         check("rst_out_valid", 32'(ov), 32'd0);
         check("rst_rd_en", 32'(rd_en_s), 32'd0);
         check("rst_out_data", 32'(od), 32'd0);
         check("rst_act_addr", 32'(aa), 32'd0);
      end
      sel = 2'd0;
      tick();

      // one neuron: addressing, 1*2 on all lanes, latency, ready gap
      t_out_ready = 1'b1;
      act_word = 32'h01010101; w_word = 32'h02020202;
      run_taps(8'd2, 8'd3, 8'd4, 0, 1'b1);
      check("flush_ready_t1", 32'(rdy), 32'd0);
      wait_out(lat, low);
      check("latency", 32'(lat), 32'd3);
      check("ready_low_before_hold", 32'(low), 32'd2);
      check("ready_in_hold", 32'(rdy), 32'd0);
      check("sum_200", 32'(od), 32'd200);
      check("out_m", 32'(om), 32'd2);
      check("out_r", 32'(orr), 32'd3);
      check("out_c", 32'(oc), 32'd4);
      tick();
      check("ready_after_hs", 32'(rdy), 32'd1);
      check("ov_after_hs", 32'(ov), 32'd0);

      // ReLU: 3 * -1 on all lanes -> -300
      act_word = 32'h03030303; w_word = 32'hffffffff;
      run_taps(8'd1, 8'd0, 8'd0, 0, 1'b0);
      wait_out(lat, low);
      check("relu_clamp", 32'(od), 32'd0);
      tick();
      sel = 2'd1;
      #1;
      run_taps(8'd1, 8'd0, 8'd0, 0, 1'b0);
      wait_out(lat, low);
      check("norelu_neg300", 32'(od), 32'h00fffed4);
      tick();

      // backpressure: distinct lanes (1,2,3,4)x(4,3,2,-1) -> 12 per tap -> 300
      sel = 2'd0;
      #1;
      t_out_ready = 1'b0;
      act_word = 32'h04030201; w_word = 32'hff020304;
      run_taps(8'd5, 8'd6, 8'd7, 0, 1'b0);
      wait_out(lat, low);
      check("bp_sum_300", 32'(od), 32'd300);
      // next neuron's first tap waits on the bus meanwhile
      act_word = 32'h01010101; w_word = 32'h01010101;
      t_m = 8'd9; t_r = 8'd8; t_c = 8'd1; t_n = 8'd0;
      t_i = 4'd0; t_j = 4'd0; t_first = 1'b1; t_last = 1'b0; t_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("bp_out_valid", 32'(ov), 32'd1);
         check("bp_out_data", 32'(od), 32'd300);
         check("bp_out_m", 32'(om), 32'd5);
         check("bp_out_r", 32'(orr), 32'd6);
         check("bp_out_c", 32'(oc), 32'd7);
         check("bp_no_rd", 32'(rd_en_s), 32'd0);
         check("bp_idx_ready", 32'(rdy), 32'd0);
      end
      t_out_ready = 1'b1;
      tick();
      check("post_hs_ov", 32'(ov), 32'd0);
      check("post_hs_ready", 32'(rdy), 32'd1);
      check("post_hs_no_rd", 32'(rd_en_s), 32'd0);
      tick();
      check("next_tap_rd", 32'(rd_en_s), 32'd1);
      check("next_act_addr", 32'(aa), 32'd257);
      check("next_w_addr", 32'(wa), 32'd225);
      run_taps(8'd9, 8'd8, 8'd1, 1, 1'b0);
      wait_out(lat, low);
      check("next_sum_loaded", 32'(od), 32'd100);
      check("next_out_m", 32'(om), 32'd9);
      tick();

      // MEM_LAT=3, two neurons back to back
      sel = 2'd2;
      #1;
      act_word = 32'h02020202; w_word = 32'h03030303;
      run_taps(8'd1, 8'd1, 8'd1, 0, 1'b0);
      wait_out(lat, low);
      check("lat3_latency", 32'(lat), 32'd5);
      check("lat3_sum_600", 32'(od), 32'd600);
      tick();
      act_word = 32'h01010101; w_word = 32'h01010101;
      run_taps(8'd2, 8'd2, 8'd2, 0, 1'b0);
      wait_out(lat, low);
      check("lat3_second_100", 32'(od), 32'd100);
      check("lat3_second_m", 32'(om), 32'd2);
      tick();

      // reset mid-FLUSH
      sel = 2'd0;
      #1;
      run_taps(8'd3, 8'd3, 8'd3, 0, 1'b0);
      check("pre_rst_rd_en", 32'(rd_en_s), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(ov), 32'd0);
      check("arst_idx_ready", 32'(rdy), 32'd1);
      check("arst_rd_en", 32'(rd_en_s), 32'd0);
      check("arst_out_data", 32'(od), 32'd0);
      #3 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("post_rst_no_out", 32'(ov), 32'd0);
      end
      act_word = 32'h02020202; w_word = 32'h01010101;
      run_taps(8'd4, 8'd4, 8'd4, 0, 1'b0);
      wait_out(lat, low);
      check("post_rst_sum_200", 32'(od), 32'd200);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end
endmodule
